// File: rtl/sprite_line_evaluator_pkg.sv
// Shared OAM word layout and evaluator state encoding for the sprite line evaluator.
package sprite_line_evaluator_pkg;

  localparam int OAM_X_W = 10;
  localparam int OAM_Y_W = 10;
  localparam int TILE_W  = 7;
  localparam int PAL_W   = 3;

  typedef struct packed {
    logic              enable;
    logic              vflip;
    logic [PAL_W-1:0]  pal;
    logic [TILE_W-1:0] tile;
    logic [OAM_Y_W-1:0] y;
    logic [OAM_X_W-1:0] x;
  } oam_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } eval_state_t;

endpackage

// File: rtl/sprite_line_evaluator_y_match.sv
// Combinational vertical coverage test and row-within-sprite for one OAM entry.
// Optional SPR_VFLIP_EN mirrors the row when the entry's vflip bit is set.
module sprite_line_evaluator_y_match
  import sprite_line_evaluator_pkg::*;
#(
  parameter int VCOUNT_W = 10,
  parameter int SPR_H = 16,
  localparam int ROW_W = $clog2(SPR_H)
) (
  input  logic [VCOUNT_W-1:0] line,
  input  logic [OAM_Y_W-1:0]  y,
  input  logic                vflip,
  output logic                hit,
  output logic [ROW_W-1:0]    row
);

  // One extra bit so y+SPR_H cannot wrap back onto small line numbers.
  localparam int CW = ((VCOUNT_W > OAM_Y_W) ? VCOUNT_W : OAM_Y_W) + 1;

  logic [CW-1:0]    line_c;
  logic [CW-1:0]    y_c;
  logic [CW-1:0]    y_end;
  logic [ROW_W-1:0] offs;

  assign line_c = CW'(line);
  assign y_c    = CW'(y);
  assign y_end  = y_c + CW'(SPR_H);
  assign hit    = (line_c >= y_c) && (line_c < y_end);
  assign offs   = ROW_W'(line_c - y_c);

`ifdef SPR_VFLIP_EN
  assign row = vflip ? (ROW_W'(SPR_H - 1) - offs) : offs;
`else
  logic unused_vflip;
  assign unused_vflip = vflip;
  assign row = offs;
`endif

endmodule

// File: rtl/sprite_line_evaluator.sv
// Per-scanline OAM scan selecting up to MAX_SPR_LINE covering sprites in index order.
// Build option SPR_VFLIP_EN enables vertical flip of the published sprite row.
module sprite_line_evaluator
  import sprite_line_evaluator_pkg::*;
#(
  parameter int NUM_OAM = 64,
  parameter int MAX_SPR_LINE = 8,
  parameter int SPR_H = 16,
  parameter int VCOUNT_W = 10,
  localparam int OAM_AW = $clog2(NUM_OAM),
  localparam int CNT_W = $clog2(MAX_SPR_LINE + 1),
  localparam int ROW_W = $clog2(SPR_H)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            line_start,
  input  logic [VCOUNT_W-1:0]             next_line,
  output logic                            oam_rd_en,
  output logic [OAM_AW-1:0]               oam_addr,
  input  logic [31:0]                     oam_rd_data,
  output logic                            busy,
  output logic                            done,
  output logic [CNT_W-1:0]                spr_count,
  output logic                            overflow,
  output logic [MAX_SPR_LINE-1:0]         slot_valid,
  output logic [MAX_SPR_LINE*OAM_X_W-1:0] slot_x,
  output logic [MAX_SPR_LINE*TILE_W-1:0]  slot_tile,
  output logic [MAX_SPR_LINE*PAL_W-1:0]   slot_pal,
  output logic [MAX_SPR_LINE*ROW_W-1:0]   slot_row
);

  eval_state_t         state;
  logic [VCOUNT_W-1:0] line;
  logic                rd_vld;
  oam_entry_t          ent;
  logic                y_hit;
  logic [ROW_W-1:0]    y_row;
  logic                hit;
  logic                full;

  assign ent  = oam_rd_data;
  assign hit  = rd_vld && ent.enable && y_hit;
  assign full = (spr_count == CNT_W'(MAX_SPR_LINE));

  sprite_line_evaluator_y_match #(
    .VCOUNT_W(VCOUNT_W),
    .SPR_H   (SPR_H)
  ) u_y_match (
    .line (line),
    .y    (ent.y),
    .vflip(ent.vflip),
    .hit  (y_hit),
    .row  (y_row)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      line       <= '0;
      rd_vld     <= 1'b0;
      oam_rd_en  <= 1'b0;
      oam_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spr_count  <= '0;
      overflow   <= 1'b0;
      slot_valid <= '0;
      slot_x     <= '0;
      slot_tile  <= '0;
      slot_pal   <= '0;
      slot_row   <= '0;
    end else if (line_start) begin
      // Also the restart path: in-flight reads of an abandoned scan are dropped.
      state      <= ST_SCAN;
      line       <= next_line;
      rd_vld     <= 1'b0;
      oam_rd_en  <= 1'b1;
      oam_addr   <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      spr_count  <= '0;
      overflow   <= 1'b0;
      slot_valid <= '0;
      slot_x     <= '0;
      slot_tile  <= '0;
      slot_pal   <= '0;
      slot_row   <= '0;
    end else begin
      done   <= 1'b0;
      rd_vld <= oam_rd_en;
      case (state)
        ST_SCAN, ST_DRAIN: begin
          if (hit && full) begin
            overflow  <= 1'b1;
            state     <= ST_DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            oam_rd_en <= 1'b0;
            oam_addr  <= '0;
            rd_vld    <= 1'b0;
          end else begin
            if (hit) begin
              for (int i = 0; i < MAX_SPR_LINE; i++) begin
                if (spr_count == CNT_W'(i)) begin
                  slot_valid[i]                <= 1'b1;
                  slot_x[i*OAM_X_W +: OAM_X_W] <= ent.x;
                  slot_tile[i*TILE_W +: TILE_W] <= ent.tile;
                  slot_pal[i*PAL_W +: PAL_W]   <= ent.pal;
                  slot_row[i*ROW_W +: ROW_W]   <= y_row;
                end
              end
              spr_count <= spr_count + CNT_W'(1);
            end
            if (state == ST_DRAIN) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (oam_addr == OAM_AW'(NUM_OAM - 1)) begin
              state     <= ST_DRAIN;
              oam_rd_en <= 1'b0;
              oam_addr  <= '0;
            end else begin
              oam_addr <= oam_addr + OAM_AW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
